wordcopy: RTL and testbench

WORDCOPY -- requirements
Module: wordcopy

---
 rtl/wordcopy_pkg.sv | 30 +++
 rtl/wordcopy_if.sv | 35 +++
 rtl/wordcopy_csr.sv | 74 +++++++
 rtl/wordcopy.sv | 121 ++++++++++++
 tb/tb_wordcopy.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wordcopy_pkg.sv
// Shared types and constants for the wordcopy engine: FSM states, CSR offsets,
// bus widths and the word address helper.
package wordcopy_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int CSR_ADDR_W = 4;
  localparam int WORD_BYTES = 4;

  localparam logic [CSR_ADDR_W-1:0] OFF_START    = 4'd0;
  localparam logic [CSR_ADDR_W-1:0] OFF_DST      = 4'd1;
  localparam logic [CSR_ADDR_W-1:0] OFF_SRC      = 4'd2;
  localparam logic [CSR_ADDR_W-1:0] OFF_CNT      = 4'd3;
  localparam logic [CSR_ADDR_W-1:0] OFF_DONE_CNT = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  // Byte address of word idx past base; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [DATA_W-1:0] idx);
    return base + idx * DATA_W'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/wordcopy_if.sv
// Bus bundle for wordcopy: CSR slave port plus memory master port.
// Modport slave is the engine's view; modport master is the environment's view.
interface wordcopy_if;
  import wordcopy_pkg::*;

  logic                  slave_waitrequest;
  logic [CSR_ADDR_W-1:0] slave_address;
  logic                  slave_read;
  logic                  slave_write;
  logic [DATA_W-1:0]     slave_writedata;
  logic [DATA_W-1:0]     slave_readdata;

  logic                  master_waitrequest;
  logic [ADDR_W-1:0]     master_address;
  logic                  master_read;
  logic                  master_write;
  logic [DATA_W-1:0]     master_readdata;
  logic                  master_readdatavalid;
  logic [DATA_W-1:0]     master_writedata;

  modport slave (
    output slave_waitrequest, slave_readdata,
    input  slave_address, slave_read, slave_write, slave_writedata,
    output master_address, master_read, master_write, master_writedata,
    input  master_waitrequest, master_readdata, master_readdatavalid
  );

  modport master (
    input  slave_waitrequest, slave_readdata,
    output slave_address, slave_read, slave_write, slave_writedata,
    input  master_address, master_read, master_write, master_writedata,
    output master_waitrequest, master_readdata, master_readdatavalid
  );

endinterface

// File: rtl/wordcopy_csr.sv
// CSR decode and storage for wordcopy. Accesses stall while the engine is busy.
// With WORDCOPY_COUNT_EN defined, offset 4 reads the live word count, never stalled.
module wordcopy_csr
  import wordcopy_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idle,
  input  logic [CSR_ADDR_W-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
`ifdef WORDCOPY_COUNT_EN
  input  logic [DATA_W-1:0]     done_cnt,
`endif
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic                  start,
  output logic [ADDR_W-1:0]     dst,
  output logic [ADDR_W-1:0]     src,
  output logic [DATA_W-1:0]     cnt
);

  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              cnt_rd;

  // Everything except the optional count register reads as zero.
  always_comb begin
    cnt_rd = 1'b0;
`ifdef WORDCOPY_COUNT_EN
    cnt_rd = read && (address == OFF_DONE_CNT);
`endif
    waitrequest = (read || write) && !idle && !cnt_rd;
    readdata    = '0;
`ifdef WORDCOPY_COUNT_EN
    if (cnt_rd) readdata = done_cnt;
`endif
  end

  always_comb begin
    dst_d = dst_q;
    src_d = src_q;
    cnt_d = cnt_q;
    start = 1'b0;
    if (write && !waitrequest) begin
      case (address)
        OFF_START: start = 1'b1;
        OFF_DST:   dst_d = writedata;
        OFF_SRC:   src_d = writedata;
        OFF_CNT:   cnt_d = writedata;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_q <= '0;
      src_q <= '0;
      cnt_q <= '0;
    end else begin
      dst_q <= dst_d;
      src_q <= src_d;
      cnt_q <= cnt_d;
    end
  end

  assign dst = dst_q;
  assign src = src_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/wordcopy.sv
// wordcopy: copies cnt 32-bit words from src to dst, one memory request in flight.
// Optional feature macro: WORDCOPY_COUNT_EN (live words-completed count at CSR offset 4).
module wordcopy
  import wordcopy_pkg::*;
(
  input logic       clk,
  input logic       rst,
  wordcopy_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] i_next;

  logic              idle;
  logic              start;
  logic [ADDR_W-1:0] dst, src;
  logic [DATA_W-1:0] cnt;
  logic              csr_wait;
  logic [DATA_W-1:0] csr_rdata;

  logic              m_read, m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  assign idle   = (state_q == ST_IDLE);
  assign i_next = i_q + DATA_W'(1);

  wordcopy_csr u_csr (
    .clk         (clk),
    .rst         (rst),
    .idle        (idle),
    .address     (bus.slave_address),
    .read        (bus.slave_read),
    .write       (bus.slave_write),
    .writedata   (bus.slave_writedata),
`ifdef WORDCOPY_COUNT_EN
    .done_cnt    (i_q),
`endif
    .waitrequest (csr_wait),
    .readdata    (csr_rdata),
    .start       (start),
    .dst         (dst),
    .src         (src),
    .cnt         (cnt)
  );

  assign bus.slave_waitrequest = csr_wait;
  assign bus.slave_readdata    = csr_rdata;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = '0;
          state_d = (cnt == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!bus.master_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // readdatavalid is honoured only here; stray pulses elsewhere are dropped.
        if (bus.master_readdatavalid) begin
          data_d  = bus.master_readdata;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (!bus.master_waitrequest) begin
          i_d     = i_next;
          state_d = (i_next < cnt) ? ST_RD_REQ : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      data_q  <= data_d;
    end
  end

  // Master signals decode straight from registered state, so they hold steady under waitrequest.
  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (state_q)
      ST_RD_REQ: begin
        m_read = 1'b1;
        m_addr = word_addr(src, i_q);
      end
      ST_WR_REQ: begin
        m_write = 1'b1;
        m_addr  = word_addr(dst, i_q);
        m_wdata = data_q;
      end
      default: ;
    endcase
  end

  assign bus.master_read      = m_read;
  assign bus.master_write     = m_write;
  assign bus.master_address   = m_addr;
  assign bus.master_writedata = m_wdata;

endmodule

// File: tb/tb_wordcopy.sv
// Self-checking bench for wordcopy: reactive memory model, transaction-level reference
// model of the copy, and a per-cycle monitor of the master port.
`timescale 1ns/1ps
module tb_wordcopy;
  import wordcopy_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wordcopy_if bus();
  wordcopy dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  logic [31:0] mem       [bit [31:0]];
  logic [31:0] model_mem [bit [31:0]];

  int n_cmp  = 0;
  int n_fail = 0;

  int cfg_waits = 0;
  int cfg_lat   = 1;
  bit cfg_noise = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_true(input string name, input bit cond);
    n_cmp++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s: got false, want true (t=%0t)", name, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input bit [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] mem_rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] model_rd(input bit [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  task automatic preload(input bit [31:0] a, input logic [31:0] d);
    mem[a]       = d;
    model_mem[a] = d;
  endtask

  // Memory slave: programmable waitrequest per request and read latency.
  initial begin
    int          wait_left;
    int          delay_left;
    bit          rd_pend;
    logic [31:0] rd_data;
    wait_left  = 0;
    delay_left = 0;
    rd_pend    = 1'b0;
    rd_data    = '0;
    bus.master_waitrequest   = 1'b0;
    bus.master_readdatavalid = 1'b0;
    bus.master_readdata      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_pend = 1'b0;
        wait_left = cfg_waits;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdatavalid = 1'b0;
        continue;
      end
      bus.master_readdatavalid = 1'b0;
      bus.master_readdata      = $urandom;
      if (rd_pend) begin
        if (delay_left == 0) begin
          bus.master_readdatavalid = 1'b1;
          bus.master_readdata      = rd_data;
          rd_pend = 1'b0;
        end else begin
          delay_left--;
        end
      end else if (cfg_noise && $urandom_range(0, 3) == 0) begin
        bus.master_readdatavalid = 1'b1;
      end
      if (bus.master_read || bus.master_write) begin
        if (wait_left > 0) begin
          bus.master_waitrequest = 1'b1;
          wait_left--;
        end else begin
          bus.master_waitrequest = 1'b0;
          if (bus.master_read) begin
            rd_pend    = 1'b1;
            rd_data    = mem_rd(bus.master_address);
            delay_left = cfg_lat - 1;
          end else begin
            mem[bus.master_address] = bus.master_writedata;
          end
          wait_left = cfg_waits;
        end
      end else begin
        bus.master_waitrequest = 1'b0;
        wait_left = cfg_waits;
      end
    end
  end

  // Master-port monitor: one strobe at a time, stability under stall, accepted transactions.
  initial begin
    bit          p_valid, p_rd, p_wr, p_wait;
    logic [31:0] p_addr, p_wdata;
    txn_t        e;
    p_valid = 1'b0;
    p_rd = 1'b0; p_wr = 1'b0; p_wait = 1'b0; p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        p_valid = 1'b0;
        continue;
      end
      if (bus.master_read || bus.master_write)
        chk_true("one_strobe", !(bus.master_read && bus.master_write));
      if (p_valid && p_wait && (p_rd || p_wr)) begin
        chk("hold_read",  32'(bus.master_read),  32'(p_rd));
        chk("hold_write", 32'(bus.master_write), 32'(p_wr));
        chk("hold_addr",  bus.master_address,    p_addr);
        chk("hold_wdata", bus.master_writedata,  p_wdata);
      end
      if ((bus.master_read || bus.master_write) && !bus.master_waitrequest) begin
        obs_q.push_back('{bus.master_write, bus.master_address, bus.master_writedata});
        if (exp_q.size() == 0) begin
          chk_true("unexpected_txn", 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("txn_kind", 32'(bus.master_write), 32'(e.wr));
          chk("txn_addr", bus.master_address, e.addr);
          if (e.wr) chk("txn_wdata", bus.master_writedata, e.data);
        end
      end
      p_valid = 1'b1;
      p_rd    = bus.master_read;
      p_wr    = bus.master_write;
      p_wait  = bus.master_waitrequest;
      p_addr  = bus.master_address;
      p_wdata = bus.master_writedata;
    end
  end

  task automatic csr_access(input bit wr, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] rdata, output int stalls);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.slave_address   = a;
    bus.slave_write     = wr;
    bus.slave_read      = !wr;
    bus.slave_writedata = d;
    @(negedge clk);
    while (bus.slave_waitrequest && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (bus.slave_waitrequest) chk_true("csr_timeout", 1'b0);
    rdata  = bus.slave_readdata;
    stalls = n;
    @(posedge clk);
    #1;
    bus.slave_write = 1'b0;
    bus.slave_read  = 1'b0;
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] cnt, input bit set_ptrs);
    logic [31:0] rd, a, d;
    int          st;
    if (set_ptrs) begin
      csr_access(1'b1, OFF_SRC, src, rd, st);
      csr_access(1'b1, OFF_DST, dst, rd, st);
    end
    csr_access(1'b1, OFF_CNT, cnt, rd, st);
    for (int k = 0; k < int'(cnt); k++) begin
      a = src + 32'(k) * 32'd4;
      d = model_rd(a);
      exp_q.push_back('{1'b0, a, 32'h0});
      exp_q.push_back('{1'b1, dst + 32'(k) * 32'd4, d});
      model_mem[dst + 32'(k) * 32'd4] = d;
    end
    csr_access(1'b1, OFF_START, $urandom, rd, st);
  endtask

  task automatic finish_copy();
    logic [31:0] rd;
    int          st;
    csr_access(1'b0, OFF_START, 32'h0, rd, st);
    chk("off0_read", rd, 32'h0);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_dst(input logic [31:0] dst, input int cnt);
    for (int k = 0; k < cnt; k++)
      chk("mem_dst", mem_rd(dst + 32'(k) * 32'd4), model_rd(dst + 32'(k) * 32'd4));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, v, prev, s, d;
    int          st, c;
    bit          found;
    bus.slave_address   = '0;
    bus.slave_read      = 1'b0;
    bus.slave_write     = 1'b0;
    bus.slave_writedata = '0;

    repeat (3) @(negedge clk);
    chk("rst_mread",  32'(bus.master_read),  32'd0);
    chk("rst_mwrite", 32'(bus.master_write), 32'd0);
    chk("rst_maddr",  bus.master_address,    32'd0);
    chk("rst_mwdata", bus.master_writedata,  32'd0);
    chk("rst_swait",  32'(bus.slave_waitrequest), 32'd0);
    chk("rst_srdata", bus.slave_readdata,    32'd0);
    #2 rst = 1'b0;

    // Idle CSR reads: zero latency, all zero.
    csr_access(1'b1, OFF_SRC, 32'h1234_5678, rd, st);
    csr_access(1'b0, OFF_SRC, 32'h0, rd, st);
    chk("rd_src_zero", rd, 32'h0);
    chk("rd_src_nostall", 32'(st), 32'd0);
    csr_access(1'b0, 4'd7, 32'h0, rd, st);
    chk("rd_unmapped_zero", rd, 32'h0);

    // Three-word copy, zero-wait memory, pinned by literals.
    preload(32'h1000, 32'hA1A1_0001);
    preload(32'h1004, 32'hB2B2_0002);
    preload(32'h1008, 32'hC3C3_0003);
    obs_q.delete();
    start_copy(32'h1000, 32'h2000, 32'd3, 1'b1);
    finish_copy();
    chk("basic_ntxn", 32'(obs_q.size()), 32'd6);
    if (obs_q.size() == 6) begin
      chk("basic_rd0_addr", obs_q[0].addr, 32'h1000);
      chk("basic_wr0_addr", obs_q[1].addr, 32'h2000);
      chk("basic_wr0_data", obs_q[1].data, 32'hA1A1_0001);
      chk("basic_rd2_addr", obs_q[4].addr, 32'h1008);
      chk("basic_wr2_addr", obs_q[5].addr, 32'h2008);
      chk("basic_wr2_data", obs_q[5].data, 32'hC3C3_0003);
    end
    chk("basic_mem_b", mem_rd(32'h2004), 32'hB2B2_0002);

    // Count zero: no strobes, offset-0 read waits at most two cycles.
    obs_q.delete();
    csr_access(1'b1, OFF_CNT, 32'd0, rd, st);
    csr_access(1'b1, OFF_START, 32'h0, rd, st);
    csr_access(1'b0, OFF_START, 32'h0, rd, st);
    chk_true("cnt0_stall_le2", st <= 2);
    chk("cnt0_rdata", rd, 32'h0);
    repeat (3) @(negedge clk);
    chk("cnt0_no_txn", 32'(obs_q.size()), 32'd0);

    // Slow memory: 3 waitrequest cycles per request, 5-cycle read latency.
    cfg_waits = 3;
    cfg_lat   = 5;
    start_copy(32'h4000, 32'h4800, 32'd3, 1'b1);
    finish_copy();
    check_dst(32'h4800, 3);

    // Source address wraps past the top of memory.
    cfg_waits = 0;
    cfg_lat   = 1;
    obs_q.delete();
    start_copy(32'hFFFF_FFFC, 32'h3000, 32'd2, 1'b1);
    finish_copy();
    if (obs_q.size() == 4) begin
      chk("wrap_rd0_addr", obs_q[0].addr, 32'hFFFF_FFFC);
      chk("wrap_rd1_addr", obs_q[2].addr, 32'h0000_0000);
    end else begin
      chk("wrap_ntxn", 32'(obs_q.size()), 32'd4);
    end
    check_dst(32'h3000, 2);

    // CSR write while busy stalls and leaves the running copy alone.
    cfg_waits = 2;
    start_copy(32'h4100, 32'h4900, 32'd3, 1'b1);
    csr_access(1'b1, OFF_DST, 32'hDEAD_0000, rd, st);
    chk_true("busy_wr_stalled", st > 0);
    finish_copy();
    check_dst(32'h4900, 3);

    // Reset during the write of word 1 of 4.
    cfg_waits = 1;
    start_copy(32'h5000, 32'h6000, 32'd4, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      #2;
      if (bus.master_write && bus.master_address == 32'h6004) found = 1'b1;
    end
    chk_true("rst_found_wr1", found);
    rst = 1'b1;
    #1;
    chk("midrst_mread",  32'(bus.master_read),  32'd0);
    chk("midrst_mwrite", 32'(bus.master_write), 32'd0);
    chk("midrst_maddr",  bus.master_address,    32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk_true("postrst_no_strobe", !bus.master_read && !bus.master_write);
    // Only the count is written: src/dst must have been cleared to 0.
    cfg_waits = 0;
    obs_q.delete();
    start_copy(32'h0, 32'h0, 32'd2, 1'b0);
    finish_copy();
    if (obs_q.size() == 4) begin
      chk("postrst_src0", obs_q[0].addr, 32'h0);
      chk("postrst_dst0", obs_q[1].addr, 32'h0);
      chk("postrst_src1", obs_q[2].addr, 32'h4);
    end else begin
      chk("postrst_ntxn", 32'(obs_q.size()), 32'd4);
    end
    start_copy(32'h7000, 32'h8000, 32'd4, 1'b1);
    finish_copy();
    check_dst(32'h8000, 4);

    // Offset 4 while busy.
    cfg_waits = 2;
    cfg_lat   = 3;
    start_copy(32'h9000, 32'hA000, 32'd4, 1'b1);
`ifdef WORDCOPY_COUNT_EN
    prev = 32'h0;
    v    = 32'h0;
    for (int n = 0; n < 400 && v != 32'd4; n++) begin
      csr_access(1'b0, OFF_DONE_CNT, 32'h0, v, st);
      chk("cnt_poll_nostall", 32'(st), 32'd0);
      chk_true("cnt_poll_monotonic", v >= prev && v <= 32'd4);
      prev = v;
    end
    chk("cnt_poll_final", v, 32'd4);
`else
    csr_access(1'b0, OFF_DONE_CNT, 32'h0, rd, st);
    chk_true("off4_stalled_busy", st > 0);
    chk("off4_rdata", rd, 32'h0);
`endif
    finish_copy();
    check_dst(32'hA000, 4);

    // Randomized copies with stray readdatavalid pulses; regions may overlap.
    cfg_noise = 1'b1;
    for (int t = 0; t < 12; t++) begin
      cfg_waits = $urandom_range(0, 3);
      cfg_lat   = $urandom_range(1, 4);
      s = 32'h0001_0000 + 32'($urandom_range(0, 63)) * 32'd4;
      d = 32'h0001_0000 + 32'($urandom_range(0, 63)) * 32'd4;
      c = $urandom_range(1, 6);
      start_copy(s, d, 32'(c), 1'b1);
      finish_copy();
      check_dst(d, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
